// File: rtl/gpio_host.sv
// gpio_host: accepts an operand pair, starts the engine, waits a bounded time
// for its result and holds that result until the consumer takes it.
module gpio_host #(
  parameter int unsigned TIMEOUT     = 255,
  parameter int unsigned ENG_LAT_MIN = 1
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [23:0] req_a1,
  input  logic [23:0] req_a2,
  output logic [23:0] A1,
  output logic [23:0] A2,
  output logic        eng_start,
  input  logic        ready,
  input  logic        valid,
  input  logic [31:0] W,
  input  logic [23:0] L,
  input  logic [1:0]  B,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_w,
  output logic [23:0] res_l,
  output logic [1:0]  res_b,
  output logic        res_timeout,
  output logic        busy,
  output logic [15:0] done_cnt
);

  localparam logic [15:0] LAT_MIN_C = 16'(ENG_LAT_MIN);
  localparam logic [15:0] TO_LAST_C = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_cnt;
  logic        w_take;
  logic        w_expire;

  // Next-state decode; a valid result beats a timeout in the same cycle
  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    w_expire    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_valid) w_state_nxt = S_LOAD;
        else           w_state_nxt = S_IDLE;
      end
      S_LOAD: begin
        if (ready) w_state_nxt = S_START;
        else       w_state_nxt = S_LOAD;
      end
      S_START: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (valid && (r_cnt >= LAT_MIN_C)) begin
          w_take      = 1'b1;
          w_state_nxt = S_DONE;
        end else if (r_cnt >= TO_LAST_C) begin
          w_expire    = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_DONE: begin
        if (res_ready) w_state_nxt = S_IDLE;
        else           w_state_nxt = S_DONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Wait counter: counts cycles since the start pulse (0 during the pulse)
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset)                                   r_cnt <= 16'd0;
    else if ((r_state == S_LOAD) && ready)          r_cnt <= 16'd0;
    else if ((r_state == S_START) || (r_state == S_WAIT)) r_cnt <= r_cnt + 16'd1;
    else                                            r_cnt <= r_cnt;
  end

  // Handshake/status outputs registered from the next state
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      req_ready <= 1'b1;
      busy      <= 1'b0;
      eng_start <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      req_ready <= (w_state_nxt == S_IDLE);
      busy      <= (w_state_nxt != S_IDLE);
      eng_start <= (w_state_nxt == S_START);
      res_valid <= (w_state_nxt == S_DONE);
    end
  end

  // Operand capture; held until the next accepted request
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      A1 <= 24'd0;
      A2 <= 24'd0;
    end else if ((r_state == S_IDLE) && req_valid) begin
      A1 <= req_a1;
      A2 <= req_a2;
    end else begin
      A1 <= A1;
      A2 <= A2;
    end
  end

  // Result capture: engine fields or the timeout marker
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      res_w       <= 32'd0;
      res_l       <= 24'd0;
      res_b       <= 2'b00;
      res_timeout <= 1'b0;
    end else if (w_take) begin
      res_w       <= W;
      res_l       <= L;
      res_b       <= B;
      res_timeout <= 1'b0;
    end else if (w_expire) begin
      res_w       <= 32'd0;
      res_l       <= 24'd0;
      res_b       <= 2'b11;
      res_timeout <= 1'b1;
    end else begin
      res_w       <= res_w;
      res_l       <= res_l;
      res_b       <= res_b;
      res_timeout <= res_timeout;
    end
  end

  // Delivered-result counter, wraps naturally at 16 bits
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset)                           done_cnt <= 16'd0;
    else if ((r_state == S_DONE) && res_ready) done_cnt <= done_cnt + 16'd1;
    else                                    done_cnt <= done_cnt;
  end

endmodule

// File: tb/tb_gpio_host.sv
// tb_gpio_host: directed and random operations against a transaction-level
// model of the host, compared every cycle, plus literal spot checks.
module tb_gpio_host;
  localparam int TIMEOUT = 255;
  localparam int LAT     = 2;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [23:0] req_a1 = 24'd0;
  logic [23:0] req_a2 = 24'd0;
  logic [23:0] A1, A2;
  logic        eng_start;
  logic        ready = 1'b0;
  logic        valid = 1'b0;
  logic [31:0] W = 32'd0;
  logic [23:0] L = 24'd0;
  logic [1:0]  B = 2'd0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res_w;
  logic [23:0] res_l;
  logic [1:0]  res_b;
  logic        res_timeout;
  logic        busy;
  logic [15:0] done_cnt;

  always #5 clk = ~clk;

  gpio_host #(.TIMEOUT(TIMEOUT), .ENG_LAT_MIN(LAT)) dut (
    .clk(clk), .n_reset(n_reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_a1(req_a1), .req_a2(req_a2), .A1(A1), .A2(A2), .eng_start(eng_start),
    .ready(ready), .valid(valid), .W(W), .L(L), .B(B), .res_valid(res_valid),
    .res_ready(res_ready), .res_w(res_w), .res_l(res_l), .res_b(res_b),
    .res_timeout(res_timeout), .busy(busy), .done_cnt(done_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      if (n_errors <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: a request is pending, a start is due, the engine
  // is running for m_age cycles, or a result awaits the consumer.
  logic        m_req, m_pulse, m_run, m_res, m_to;
  int          m_age;
  logic [23:0] m_a1, m_a2, m_l;
  logic [31:0] m_w;
  logic [1:0]  m_b;
  logic [15:0] m_cnt;

  task automatic model_step();
    if (!n_reset) begin
      m_req = 1'b0; m_pulse = 1'b0; m_run = 1'b0; m_res = 1'b0; m_age = 0;
      m_a1 = 24'd0; m_a2 = 24'd0; m_w = 32'd0; m_l = 24'd0; m_b = 2'd0;
      m_to = 1'b0; m_cnt = 16'd0;
    end else if (m_res) begin
      if (res_ready) begin m_res = 1'b0; m_cnt = m_cnt + 16'd1; end
    end else if (m_run) begin
      if (valid && m_age >= LAT) begin
        m_w = W; m_l = L; m_b = B; m_to = 1'b0; m_run = 1'b0; m_res = 1'b1;
      end else if (m_age + 1 >= TIMEOUT) begin
        m_w = 32'd0; m_l = 24'd0; m_b = 2'b11; m_to = 1'b1; m_run = 1'b0; m_res = 1'b1;
      end else begin
        m_age++;
      end
    end else if (m_pulse) begin
      m_pulse = 1'b0; m_run = 1'b1; m_age = 1;
    end else if (m_req) begin
      if (ready) begin m_req = 1'b0; m_pulse = 1'b1; end
    end else if (req_valid) begin
      m_a1 = req_a1; m_a2 = req_a2; m_req = 1'b1;
    end
  endtask

  task automatic compare_all();
    logic idle_v;
    idle_v = !(m_req || m_pulse || m_run || m_res);
    chk("req_ready", 64'(req_ready), 64'(idle_v));
    chk("busy", 64'(busy), 64'(!idle_v));
    chk("eng_start", 64'(eng_start), 64'(m_pulse));
    chk("res_valid", 64'(res_valid), 64'(m_res));
    chk("A1", 64'(A1), 64'(m_a1));
    chk("A2", 64'(A2), 64'(m_a2));
    chk("res_w", 64'(res_w), 64'(m_w));
    chk("res_l", 64'(res_l), 64'(m_l));
    chk("res_b", 64'(res_b), 64'(m_b));
    chk("res_timeout", 64'(res_timeout), 64'(m_to));
    chk("done_cnt", 64'(done_cnt), 64'(m_cnt));
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      compare_all();
    end
  end

  // Engine stand-in: drops valid on start (or one step late when lazy),
  // raises valid with new fields e_delay steps later.
  logic        e_busy = 1'b0, e_never = 1'b0, e_lazy = 1'b0, e_hold = 1'b0;
  logic        rdy_force = 1'b1, rdy_val = 1'b1;
  int          e_cd = 0, e_delay = 1;
  logic [31:0] e_w = 32'd0;
  logic [23:0] e_l = 24'd0;
  logic [1:0]  e_b = 2'd0;

  task automatic eng_step();
    if (eng_start) begin
      if (!e_lazy) valid = 1'b0;
      e_hold = e_lazy;
      if (!e_never) begin e_busy = 1'b1; e_cd = e_delay; ready = 1'b0; end
    end else if (e_busy) begin
      if (e_hold) e_hold = 1'b0;
      else        valid = 1'b0;
      e_cd = e_cd - 1;
      if (e_cd == 0) begin valid = 1'b1; W = e_w; L = e_l; B = e_b; e_busy = 1'b0; end
    end
    if (!e_busy) ready = rdy_force ? rdy_val : ($urandom_range(0, 3) != 0);
  endtask

  task automatic set_eng(input int d, input logic [31:0] w, input logic [23:0] l,
                         input logic [1:0] b, input logic never, input logic lazy);
    e_delay = d; e_w = w; e_l = l; e_b = b; e_never = never; e_lazy = lazy;
  endtask

  task automatic tick();
    @(negedge clk);
    eng_step();
  endtask

  task automatic issue(input logic [23:0] a1, input logic [23:0] a2);
    logic acc;
    acc = 1'b0;
    req_a1 = a1; req_a2 = a2; req_valid = 1'b1;
    for (int i = 0; i < 20 && !acc; i++) begin
      tick();
      if (busy) acc = 1'b1;
    end
    req_valid = 1'b0;
    chk("req_accepted", 64'(acc), 64'd1);
  endtask

  task automatic wait_res(input int max, output int n_start, output int lat);
    logic got;
    got = 1'b0; n_start = 0; lat = -1;
    for (int i = 0; i < max && !got; i++) begin
      tick();
      if (eng_start) begin n_start++; lat = 0; end
      else if (lat >= 0) lat++;
      if (res_valid) got = 1'b1;
    end
    chk("res_valid_seen", 64'(got), 64'd1);
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  initial begin
    int ns, lat, gap;
    logic seen;
    repeat (3) tick();
    n_reset = 1'b1;
    tick();
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_done_cnt", 64'(done_cnt), 64'd0);

    // Single operation with known result
    set_eng(5, 32'hDEADBEEF, 24'h000010, 2'b01, 1'b0, 1'b0);
    issue(24'h123456, 24'h789abc);
    wait_res(50, ns, lat);
    chk("op1_starts", 64'(ns), 64'd1);
    chk("op1_latency", 64'(lat), 64'd6);
    chk("op1_w", 64'(res_w), 64'hDEADBEEF);
    chk("op1_l", 64'(res_l), 64'h10);
    chk("op1_b", 64'(res_b), 64'd1);
    chk("op1_to", 64'(res_timeout), 64'd0);
    handshake();
    chk("op1_done_cnt", 64'(done_cnt), 64'd1);

    // Stale valid held across the start must not be captured
    set_eng(4, 32'hCAFEF00D, 24'h000ABC, 2'b10, 1'b0, 1'b1);
    issue(24'h000111, 24'h000222);
    wait_res(50, ns, lat);
    chk("stale_w", 64'(res_w), 64'hCAFEF00D);
    handshake();
    chk("op2_done_cnt", 64'(done_cnt), 64'd2);

    // Engine not ready for 20 cycles
    rdy_val = 1'b0;
    set_eng(3, 32'h0000_0777, 24'h000777, 2'b00, 1'b0, 1'b0);
    issue(24'h1, 24'h2);
    ns = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (eng_start) ns++;
    end
    chk("load_no_start", 64'(ns), 64'd0);
    chk("load_A1", 64'(A1), 64'd1);
    chk("load_A2", 64'(A2), 64'd2);
    rdy_val = 1'b1;
    tick();
    chk("start_not_early", 64'(eng_start), 64'd0);
    tick();
    chk("start_after_ready", 64'(eng_start), 64'd1);
    wait_res(40, ns, lat);
    handshake();

    // Engine never answers: timeout result
    set_eng(1, 32'h0, 24'h0, 2'b00, 1'b1, 1'b0);
    issue(24'h5, 24'h6);
    wait_res(300, ns, lat);
    chk("to_latency", 64'(lat), 64'd255);
    chk("to_w", 64'(res_w), 64'd0);
    chk("to_l", 64'(res_l), 64'd0);
    chk("to_b", 64'(res_b), 64'd3);
    chk("to_flag", 64'(res_timeout), 64'd1);
    handshake();

    // Valid arrives in the last waiting cycle: valid wins
    set_eng(254, 32'h13572468, 24'h00BEEF, 2'b10, 1'b0, 1'b0);
    issue(24'h7, 24'h8);
    wait_res(300, ns, lat);
    chk("race_latency", 64'(lat), 64'd255);
    chk("race_to", 64'(res_timeout), 64'd0);
    chk("race_w", 64'(res_w), 64'h13572468);
    handshake();

    // Consumer stalls with a new request waiting
    set_eng(3, 32'hABCD0123, 24'h000321, 2'b01, 1'b0, 1'b0);
    issue(24'h7, 24'h8);
    wait_res(50, ns, lat);
    set_eng(2, 32'h0BADCAFE, 24'h000999, 2'b11, 1'b0, 1'b0);
    req_a1 = 24'h9; req_a2 = 24'hA; req_valid = 1'b1;
    ns = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (eng_start) ns++;
      chk("stall_req_ready", 64'(req_ready), 64'd0);
      chk("stall_res_w", 64'(res_w), 64'hABCD0123);
    end
    chk("stall_no_start", 64'(ns), 64'd0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("hs_idle", 64'(req_ready), 64'd1);
    chk("hs_A1_held", 64'(A1), 64'd7);
    tick();
    req_valid = 1'b0;
    chk("b2b_busy", 64'(busy), 64'd1);
    chk("b2b_A1", 64'(A1), 64'd9);
    wait_res(50, ns, lat);
    chk("b2b_w", 64'(res_w), 64'h0BADCAFE);
    handshake();
    chk("b2b_done_cnt", 64'(done_cnt), 64'd7);

    // Reset in the middle of waiting
    set_eng(30, 32'h55555555, 24'h555555, 2'b01, 1'b0, 1'b0);
    issue(24'h00AAAA, 24'h00BBBB);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (eng_start) seen = 1'b1;
    end
    chk("rst_op_started", 64'(seen), 64'd1);
    repeat (3) tick();
    n_reset = 1'b0;
    #1;
    chk("arst_req_ready", 64'(req_ready), 64'd1);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_eng_start", 64'(eng_start), 64'd0);
    chk("arst_res_valid", 64'(res_valid), 64'd0);
    chk("arst_A1", 64'(A1), 64'd0);
    chk("arst_A2", 64'(A2), 64'd0);
    chk("arst_res_w", 64'(res_w), 64'd0);
    chk("arst_res_b", 64'(res_b), 64'd0);
    chk("arst_res_to", 64'(res_timeout), 64'd0);
    chk("arst_done_cnt", 64'(done_cnt), 64'd0);
    e_busy = 1'b0; valid = 1'b0;
    tick();
    n_reset = 1'b1;
    tick();
    chk("post_rst_req_ready", 64'(req_ready), 64'd1);
    chk("post_rst_res_valid", 64'(res_valid), 64'd0);
    set_eng(3, 32'h00000034, 24'h000034, 2'b01, 1'b0, 1'b0);
    issue(24'h3, 24'h4);
    wait_res(50, ns, lat);
    chk("post_rst_A1", 64'(A1), 64'd3);
    chk("post_rst_A2", 64'(A2), 64'd4);
    chk("post_rst_w", 64'(res_w), 64'h34);
    handshake();
    chk("post_rst_done_cnt", 64'(done_cnt), 64'd1);

    // Random operations with a wandering ready and consumer
    rdy_force = 1'b0;
    for (int k = 0; k < 60; k++) begin
      int d;
      d = int'($urandom_range(1, 12));
      set_eng(d, $urandom, 24'($urandom), 2'($urandom), ($urandom_range(0, 19) == 0),
              (d >= 3) && ($urandom_range(0, 1) == 1));
      issue(24'($urandom), 24'($urandom));
      wait_res(400, ns, lat);
      gap = int'($urandom_range(0, 3));
      repeat (gap) tick();
      handshake();
      gap = int'($urandom_range(0, 2));
      repeat (gap) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
